// File: rtl/srl_delay_pkg.sv
// Shared helpers and types for the variable-depth delay line.
// Used by srl_delay_line_if, srl_tap_chain and srl_delay_line.
package srl_delay_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // delay_sel has to encode 0..max_delay inclusive
  function automatic int delay_w(input int max_delay);
    int w;
    w = clog2(max_delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int SRL_DEF_WIDTH     = 16;
  localparam int SRL_DEF_MAX_DELAY = 32;
  localparam int SRL_DEF_DELAY_W   = delay_w(SRL_DEF_MAX_DELAY);

  typedef struct packed {
    logic                     vld;
    logic [SRL_DEF_WIDTH-1:0] data;
  } srl_stage_t;

endpackage

// File: rtl/srl_delay_line_if.sv
// Stream-side bundle of the delay line: control, input sample and delayed output.
interface srl_delay_line_if
  import srl_delay_pkg::*;
#(
  parameter int C_WIDTH   = SRL_DEF_WIDTH,
  parameter int C_DELAY_W = SRL_DEF_DELAY_W
);
  logic                 ce;
  logic                 flush;
  logic [C_DELAY_W-1:0] delay_sel;
  logic [C_WIDTH-1:0]   data_in;
  logic                 valid_in;
  logic [C_WIDTH-1:0]   data_out;
  logic                 valid_out;
  logic                 primed;

  modport master (
    output ce, flush, delay_sel, data_in, valid_in,
    input  data_out, valid_out, primed
  );

  modport slave (
    input  ce, flush, delay_sel, data_in, valid_in,
    output data_out, valid_out, primed
  );
endinterface

// File: rtl/srl_tap_chain.sv
// C_MAX_DELAY-stage {valid, data} shift array with clock enable,
// valid-only clear and a tap mux returning stage[tap_sel-1].
module srl_tap_chain
  import srl_delay_pkg::*;
#(
  parameter int C_WIDTH     = SRL_DEF_WIDTH,
  parameter int C_MAX_DELAY = SRL_DEF_MAX_DELAY,
  parameter int C_DELAY_W   = delay_w(C_MAX_DELAY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 clr_vld,
  input  logic                 valid_in,
  input  logic [C_WIDTH-1:0]   data_in,
  input  logic [C_DELAY_W-1:0] tap_sel,
  output logic                 tap_vld,
  output logic [C_WIDTH-1:0]   tap_data
);

  typedef struct packed {
    logic               vld;
    logic [C_WIDTH-1:0] data;
  } stage_t;

  stage_t stage [C_MAX_DELAY];
  stage_t tap;

  // clr_vld wins over ce so a flush drops the same-cycle input and freezes the shift
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < C_MAX_DELAY; k++) stage[k] <= '0;
    end else if (clr_vld) begin
      for (int k = 0; k < C_MAX_DELAY; k++) stage[k].vld <= 1'b0;
    end else if (ce) begin
      stage[0] <= '{vld: valid_in, data: data_in};
      for (int k = 1; k < C_MAX_DELAY; k++) stage[k] <= stage[k-1];
    end
  end

  // tap_sel == 0 matches no stage; the caller supplies the pass-through path
  always_comb begin
    tap = '0;
    for (int k = 0; k < C_MAX_DELAY; k++) begin
      if (tap_sel == C_DELAY_W'(k + 1)) tap = stage[k];
    end
  end

  assign tap_vld  = tap.vld;
  assign tap_data = tap.data;

endmodule

// File: rtl/srl_delay_line.sv
// Runtime-selectable delay line with valid sideband, flush and ce stall.
// Optional fill tracking enabled by defining SRL_DELAY_PRIMED_EN.
module srl_delay_line
  import srl_delay_pkg::*;
#(
  parameter int C_WIDTH     = SRL_DEF_WIDTH,
  parameter int C_MAX_DELAY = SRL_DEF_MAX_DELAY,
  parameter int C_OUT_REG   = 0
) (
  input logic             clk,
  input logic             rst,
  srl_delay_line_if.slave bus
);

  localparam int C_DELAY_W = delay_w(C_MAX_DELAY);

  function automatic logic [C_DELAY_W-1:0] clamp_delay(input logic [C_DELAY_W-1:0] sel);
    return (sel > C_DELAY_W'(C_MAX_DELAY)) ? C_DELAY_W'(C_MAX_DELAY) : sel;
  endfunction

  logic [C_DELAY_W-1:0] delay_q;
  logic                 tap_vld_p0;
  logic [C_WIDTH-1:0]   tap_data_p0;
  logic                 vld_p0;
  logic [C_WIDTH-1:0]   data_p0;

  // delay_sel is only looked at on rst/flush; streaming never retimes the line
  always_ff @(posedge clk) begin
    if (rst || bus.flush) delay_q <= clamp_delay(bus.delay_sel);
  end

  srl_tap_chain #(
    .C_WIDTH     (C_WIDTH),
    .C_MAX_DELAY (C_MAX_DELAY),
    .C_DELAY_W   (C_DELAY_W)
  ) u_chain (
    .clk      (clk),
    .rst      (rst),
    .ce       (bus.ce),
    .clr_vld  (bus.flush),
    .valid_in (bus.valid_in),
    .data_in  (bus.data_in),
    .tap_sel  (delay_q),
    .tap_vld  (tap_vld_p0),
    .tap_data (tap_data_p0)
  );

  // stage p0: tap select, zero delay bypasses the chain
  always_comb begin
    vld_p0  = tap_vld_p0;
    data_p0 = tap_data_p0;
    if (delay_q == '0) begin
      vld_p0  = bus.valid_in;
      data_p0 = bus.data_in;
    end
  end

  generate
    if (C_OUT_REG != 0) begin : g_out_reg
      logic               vld_p1;
      logic [C_WIDTH-1:0] data_p1;

      // stage p1: optional output register
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else if (bus.flush) begin
          vld_p1  <= 1'b0;
        end else if (bus.ce) begin
          vld_p1  <= vld_p0;
          data_p1 <= data_p0;
        end
      end

      assign bus.valid_out = vld_p1;
      assign bus.data_out  = data_p1;
    end else begin : g_no_out_reg
      assign bus.valid_out = vld_p0;
      assign bus.data_out  = data_p0;
    end
  endgenerate

`ifdef SRL_DELAY_PRIMED_EN
  logic [C_DELAY_W-1:0] fill_cnt;
  logic [C_DELAY_W-1:0] fill_nxt;
  logic                 primed_q;

  assign fill_nxt = (fill_cnt == delay_q) ? fill_cnt : fill_cnt + C_DELAY_W'(1);

  // primed compares against the post-update count so it rises on the d-th ce edge
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      fill_cnt <= '0;
      primed_q <= (clamp_delay(bus.delay_sel) == '0);
    end else if (bus.ce) begin
      fill_cnt <= fill_nxt;
      primed_q <= (fill_nxt == delay_q);
    end
  end

  assign bus.primed = primed_q;
`else
  assign bus.primed = 1'b1;
`endif

endmodule

// File: tb/tb_srl_delay_line.sv
// Bench for srl_delay_line: two instances (with and without output register)
// driven in lockstep and checked against a latency scoreboard.
module tb_srl_delay_line;
  import srl_delay_pkg::*;

  localparam int W    = 16;
  localparam int MAXD = 32;
  localparam int DW   = delay_w(MAXD);

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          flush;
  logic          vin;
  logic [DW-1:0] sel;
  logic [W-1:0]  din;

  always #5 clk = ~clk;

  srl_delay_line_if #(.C_WIDTH(W), .C_DELAY_W(DW)) bus0 ();
  srl_delay_line_if #(.C_WIDTH(W), .C_DELAY_W(DW)) bus1 ();

  assign bus0.ce = ce;  assign bus0.flush = flush;  assign bus0.delay_sel = sel;
  assign bus0.data_in = din;  assign bus0.valid_in = vin;
  assign bus1.ce = ce;  assign bus1.flush = flush;  assign bus1.delay_sel = sel;
  assign bus1.data_in = din;  assign bus1.valid_in = vin;

  srl_delay_line #(.C_WIDTH(W), .C_MAX_DELAY(MAXD), .C_OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  srl_delay_line #(.C_WIDTH(W), .C_MAX_DELAY(MAXD), .C_OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } item_t;

  typedef struct {
    int sel;
    int lat;
    bit tog;
    int n;
  } vec_t;

  item_t q[$];
  int    cnt = 0;
  int    d_m = 0;
  int    fill_m = 0;
  logic  primed_m = 1'b0;
  bit    model_ok = 1'b0;
  bit    meas_on = 1'b0;
  int    first_c = -1;
  int    seen_c = -1;
  bit    seen_dead = 1'b0;
  int    total = 0;
  int    bad = 0;

  function automatic int clampi(input int s);
    return (s > MAXD) ? MAXD : s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock: drive, check at negedge, advance the model at posedge
  task automatic cyc(input logic r, input logic c, input logic f, input logic v,
                     input logic [W-1:0] dv);
    bit           e0, e1;
    logic [W-1:0] ed0, ed1;
    rst = r; ce = c; flush = f; vin = v; din = dv;
    if (!r && !f && c && v) begin
      q.push_back('{dv, cnt + d_m});
      if (meas_on && first_c < 0) first_c = cnt;
    end
    @(negedge clk);
    if (model_ok) begin
      while (q.size() > 0 && q[0].due + 1 < cnt) void'(q.pop_front());
      e0 = 0; e1 = 0; ed0 = '0; ed1 = '0;
      foreach (q[i]) begin
        if (q[i].due == cnt)     begin e0 = 1; ed0 = q[i].data; end
        if (q[i].due + 1 == cnt) begin e1 = 1; ed1 = q[i].data; end
      end
      chk("valid_out0", 32'(bus0.valid_out), 32'(e0));
      if (e0) chk("data_out0", 32'(bus0.data_out), 32'(ed0));
      chk("valid_out1", 32'(bus1.valid_out), 32'(e1));
      if (e1) chk("data_out1", 32'(bus1.data_out), 32'(ed1));
`ifdef SRL_DELAY_PRIMED_EN
      chk("primed0", 32'(bus0.primed), 32'(primed_m));
      chk("primed1", 32'(bus1.primed), 32'(primed_m));
`else
      chk("primed0", 32'(bus0.primed), 32'd1);
      chk("primed1", 32'(bus1.primed), 32'd1);
`endif
      if (meas_on && first_c >= 0 && seen_c < 0 && bus0.valid_out === 1'b1) seen_c = cnt;
      if (bus0.valid_out === 1'b1 && bus0.data_out === 16'hDEAD) seen_dead = 1'b1;
    end
    @(posedge clk);
    if (r || f) begin
      q.delete();
      d_m      = clampi(int'(sel));
      fill_m   = 0;
      primed_m = (d_m == 0);
      if (r) model_ok = 1'b1;
    end else if (c) begin
      cnt++;
      if (fill_m < d_m) fill_m++;
      primed_m = (fill_m == d_m);
    end
    #1;
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{sel: 5,  lat: 5,  tog: 0, n: 20};
    vt[1] = '{sel: 4,  lat: 4,  tog: 1, n: 12};
    vt[2] = '{sel: 40, lat: 32, tog: 0, n: 10};
    vt[3] = '{sel: 0,  lat: 0,  tog: 0, n: 8};
    vt[4] = '{sel: 1,  lat: 1,  tog: 1, n: 6};
    vt[5] = '{sel: 32, lat: 32, tog: 1, n: 4};

    rst = 1'b1; ce = 1'b0; flush = 1'b0; vin = 1'b0; din = '0; sel = '0;
    @(posedge clk); #1;

    // table-driven latency/stall/clamp vectors
    for (int i = 0; i < 6; i++) begin
      int k, ph;
      sel = DW'(vt[i].sel);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      chk("rst_data0", 32'(bus0.data_out), 32'd0);
      chk("rst_data1", 32'(bus1.data_out), 32'd0);
      chk("rst_valid1", 32'(bus1.valid_out), 32'd0);
      sel = DW'($urandom_range(0, 63));
      meas_on = 1'b1; first_c = -1; seen_c = -1;
      k = 1; ph = 0;
      while (k <= vt[i].n) begin
        logic c;
        c = vt[i].tog ? ((ph % 2) == 0) : 1'b1;
        cyc(1'b0, c, 1'b0, c, W'(16'h0100 * i + k));
        if (c) k++;
        ph++;
      end
      for (int j = 0; j < vt[i].lat + 3; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("latency", 32'(seen_c - first_c), 32'(vt[i].lat));
      meas_on = 1'b0;
    end

    // mid-stream flush with delay 4 -> 7; flush-cycle sample must vanish
    sel = DW'(4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 10; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, W'(100 + k));
    sel = DW'(7);
    seen_dead = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hDEAD);
    meas_on = 1'b1; first_c = -1; seen_c = -1;
    for (int k = 1; k <= 10; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, W'(200 + k));
    for (int j = 0; j < 10; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("flush_latency", 32'(seen_c - first_c), 32'd7);
    chk("flush_dropped", 32'(seen_dead), 32'd0);
    meas_on = 1'b0;

    // reset with three samples in flight
    sel = DW'(8);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, W'(300 + k));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("abort_valid0", 32'(bus0.valid_out), 32'd0);
    chk("abort_valid1", 32'(bus1.valid_out), 32'd0);
    for (int j = 0; j < 10; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, W'(400 + k));
    for (int j = 0; j < 12; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // fill tracking at delay 6, including stalls and a flush
    sel = DW'(6);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int j = 0; j < 8; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
